entrada_decimal: RTL and testbench

Sequential decimal-entry block: the input-side counterpart of the seven-segment decimal display driver. It accumulates BCD digits keyed in from board switches and a key into a binary value, up to 4 digits (0..9999). On confirmation it hands the value to the processor through a valid/acknowledge handshake. It also exposes the partial value and digit count so the display driver can echo the entry in progress.

---
 rtl/entrada_decimal.sv | 130 +++++++++++++
 tb/tb_entrada_decimal.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/entrada_decimal.sv
// Decimal keypad entry: accumulates up to four BCD digits into a binary
// value and hands committed values to the processor via valid/acknowledge.
module entrada_decimal (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  digito,
    input  logic        tecla,
    input  logic        confirma,
    input  logic        apaga,
    input  logic        lido,
    output logic [31:0] valor,
    output logic        valido,
    output logic [13:0] parcial,
    output logic [2:0]  num_digitos,
    output logic        erro
);

    typedef enum logic {
        COLETA,
        PRONTO
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic        r_tecla_q;
    logic        r_conf_q;
    logic        r_apaga_q;
    logic [13:0] r_parcial;
    logic [13:0] w_parcial_n;
    logic [2:0]  r_num;
    logic [2:0]  w_num_n;
    logic [13:0] r_valor;
    logic [13:0] w_valor_n;
    logic        r_valido;
    logic        w_valido_n;
    logic        r_erro;
    logic        w_erro_n;

    logic        w_tecla_e;
    logic        w_conf_e;
    logic        w_apaga_e;
    logic [13:0] w_mul10;

    assign w_tecla_e = tecla & ~r_tecla_q;
    assign w_conf_e  = confirma & ~r_conf_q;
    assign w_apaga_e = apaga & ~r_apaga_q;

    // p*10 + d as shifts; four digits max keeps this within 14 bits
    assign w_mul10 = (r_parcial << 3) + (r_parcial << 1)
                   + {10'd0, digito};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= COLETA;
            r_tecla_q <= 1'b1;
            r_conf_q  <= 1'b1;
            r_apaga_q <= 1'b1;
            r_parcial <= '0;
            r_num     <= '0;
            r_valor   <= '0;
            r_valido  <= 1'b0;
            r_erro    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_tecla_q <= tecla;
            r_conf_q  <= confirma;
            r_apaga_q <= apaga;
            r_parcial <= w_parcial_n;
            r_num     <= w_num_n;
            r_valor   <= w_valor_n;
            r_valido  <= w_valido_n;
            r_erro    <= w_erro_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_parcial_n = r_parcial;
        w_num_n     = r_num;
        w_valor_n   = r_valor;
        w_valido_n  = r_valido;
        w_erro_n    = 1'b0;
        case (r_state)
            COLETA: begin
                if (w_apaga_e) begin
                    w_parcial_n = '0;
                    w_num_n     = '0;
                end else if (w_conf_e) begin
                    if (r_num != 3'd0) begin
                        w_valor_n   = r_parcial;
                        w_valido_n  = 1'b1;
                        w_parcial_n = '0;
                        w_num_n     = '0;
                        w_state_n   = PRONTO;
                    end else begin
                        w_erro_n = 1'b1;
                    end
                end else if (w_tecla_e) begin
                    if (digito > 4'd9 || r_num == 3'd4) begin
                        w_erro_n = 1'b1;
                    end else begin
                        w_parcial_n = w_mul10;
                        w_num_n     = r_num + 3'd1;
                    end
                end
            end
            PRONTO: begin
                // Key edges arriving with lido are still judged as PRONTO
                if (lido) begin
                    w_valido_n = 1'b0;
                    w_state_n  = COLETA;
                end
                if (w_apaga_e) begin
                    w_parcial_n = '0;
                    w_num_n     = '0;
                end else if (w_conf_e || w_tecla_e) begin
                    w_erro_n = 1'b1;
                end
            end
            default: w_state_n = COLETA;
        endcase
    end

    assign valor       = {18'd0, r_valor};
    assign valido      = r_valido;
    assign parcial     = r_parcial;
    assign num_digitos = r_num;
    assign erro        = r_erro;

endmodule

// File: tb/tb_entrada_decimal.sv
// Bench for entrada_decimal: directed vector table followed by
// randomized key activity checked against a digit-queue model.
module tb_entrada_decimal;

    logic        clock;
    logic        reset;
    logic [3:0]  digito;
    logic        tecla;
    logic        confirma;
    logic        apaga;
    logic        lido;
    logic [31:0] valor;
    logic        valido;
    logic [13:0] parcial;
    logic [2:0]  num_digitos;
    logic        erro;

    entrada_decimal dut (
        .clock      (clock),
        .reset      (reset),
        .digito     (digito),
        .tecla      (tecla),
        .confirma   (confirma),
        .apaga      (apaga),
        .lido       (lido),
        .valor      (valor),
        .valido     (valido),
        .parcial    (parcial),
        .num_digitos(num_digitos),
        .erro       (erro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit       rst_n;
        bit [3:0] d;
        bit       t;
        bit       c;
        bit       a;
        bit       l;
        int       p;
        int       n;
        bit       v;
        int       val;
        bit       e;
    } vec_t;

    vec_t tab[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: entered digits kept as a queue
    int   m_digs[$];
    bit   m_pend;
    int   m_val;
    bit   m_err;
    bit   m_pt, m_pc, m_pa;

    function automatic int qval();
        int v = 0;
        foreach (m_digs[i]) v = v * 10 + m_digs[i];
        return v;
    endfunction

    function automatic void model_step(bit rst_n, int d, bit t, bit c,
                                       bit a, bit l);
        bit et, ec, ea;
        if (!rst_n) begin
            m_digs.delete();
            m_pend = 0;
            m_val  = 0;
            m_err  = 0;
            m_pt   = 1;
            m_pc   = 1;
            m_pa   = 1;
            return;
        end
        et    = t && !m_pt;
        ec    = c && !m_pc;
        ea    = a && !m_pa;
        m_err = 0;
        if (m_pend) begin
            if (l) m_pend = 0;
            if (ea) m_digs.delete();
            else if (ec || et) m_err = 1;
        end else begin
            if (ea) begin
                m_digs.delete();
            end else if (ec) begin
                if (m_digs.size() == 0) begin
                    m_err = 1;
                end else begin
                    m_val  = qval();
                    m_pend = 1;
                    m_digs.delete();
                end
            end else if (et) begin
                if (d > 9 || m_digs.size() >= 4) m_err = 1;
                else m_digs.push_back(d);
            end
        end
        m_pt = t;
        m_pc = c;
        m_pa = a;
    endfunction

    function automatic void add(bit r, int d, bit t, bit c, bit a,
                                bit l, int p, int n, bit v, int val,
                                bit e);
        vec_t x;
        x.rst_n = r;
        x.d     = d[3:0];
        x.t     = t;
        x.c     = c;
        x.a     = a;
        x.l     = l;
        x.p     = p;
        x.n     = n;
        x.v     = v;
        x.val   = val;
        x.e     = e;
        tab.push_back(x);
    endfunction

    task automatic cycle(bit r, int d, bit t, bit c, bit a, bit l);
        reset    = r;
        digito   = d[3:0];
        tecla    = t;
        confirma = c;
        apaga    = a;
        lido     = l;
        @(posedge clock);
        #1;
        model_step(r, d, t, c, a, l);
    endtask

    function automatic void check(string nm, int p, int n, bit v,
                                  int val, bit e);
        total++;
        if (parcial !== p[13:0] || num_digitos !== n[2:0] ||
            valido !== v || valor !== val || erro !== e) begin
            bad++;
            $display("FAIL %s got p=%0d n=%0d v=%0b val=%0d e=%0b want p=%0d n=%0d v=%0b val=%0d e=%0b",
                     nm, parcial, num_digitos, valido, valor, erro,
                     p, n, v, val, e);
        end
    endfunction

    initial begin
        bit rt, rc, ra;
        reset    = 1'b0;
        digito   = '0;
        tecla    = 1'b0;
        confirma = 1'b0;
        apaga    = 1'b0;
        lido     = 1'b0;

        // reset with tecla held: no digit afterwards
        add(0,5,1,0,0,0,     0,0,0,0,0);
        add(0,5,1,0,0,0,     0,0,0,0,0);
        add(1,5,1,0,0,0,     0,0,0,0,0);
        add(1,5,0,0,0,0,     0,0,0,0,0);
        // 4,0,9,5 then confirm
        add(1,4,1,0,0,0,     4,1,0,0,0);
        add(1,4,0,0,0,0,     4,1,0,0,0);
        add(1,0,1,0,0,0,     40,2,0,0,0);
        add(1,0,0,0,0,0,     40,2,0,0,0);
        add(1,9,1,0,0,0,     409,3,0,0,0);
        add(1,9,0,0,0,0,     409,3,0,0,0);
        add(1,5,1,0,0,0,     4095,4,0,0,0);
        add(1,5,0,0,0,0,     4095,4,0,0,0);
        add(1,0,0,1,0,0,     0,0,1,4095,0);
        add(1,0,0,0,0,0,     0,0,1,4095,0);
        // keys while pending, then acknowledge
        add(1,3,1,0,0,0,     0,0,1,4095,1);
        add(1,3,0,0,0,0,     0,0,1,4095,0);
        add(1,0,0,1,0,0,     0,0,1,4095,1);
        add(1,0,0,0,0,0,     0,0,1,4095,0);
        add(1,0,0,0,0,1,     0,0,0,4095,0);
        add(1,0,0,0,0,0,     0,0,0,4095,0);
        // 9999, fifth digit, then illegal code on fresh entry
        add(1,9,1,0,0,0,     9,1,0,4095,0);
        add(1,9,0,0,0,0,     9,1,0,4095,0);
        add(1,9,1,0,0,0,     99,2,0,4095,0);
        add(1,9,0,0,0,0,     99,2,0,4095,0);
        add(1,9,1,0,0,0,     999,3,0,4095,0);
        add(1,9,0,0,0,0,     999,3,0,4095,0);
        add(1,9,1,0,0,0,     9999,4,0,4095,0);
        add(1,9,0,0,0,0,     9999,4,0,4095,0);
        add(1,7,1,0,0,0,     9999,4,0,4095,1);
        add(1,7,0,0,0,0,     9999,4,0,4095,0);
        add(1,0,0,0,1,0,     0,0,0,4095,0);
        add(1,0,0,0,0,0,     0,0,0,4095,0);
        add(1,12,1,0,0,0,    0,0,0,4095,1);
        add(1,12,0,0,0,0,    0,0,0,4095,0);
        // 3,8 then apaga+confirma together, then empty confirm
        add(1,3,1,0,0,0,     3,1,0,4095,0);
        add(1,3,0,0,0,0,     3,1,0,4095,0);
        add(1,8,1,0,0,0,     38,2,0,4095,0);
        add(1,8,0,0,0,0,     38,2,0,4095,0);
        add(1,0,0,1,1,0,     0,0,0,4095,0);
        add(1,0,0,0,0,0,     0,0,0,4095,0);
        add(1,0,0,1,0,0,     0,0,0,4095,1);
        // back-to-back rejects: held confirma, new bad tecla
        add(1,11,1,1,0,0,    0,0,0,4095,1);
        add(1,0,0,0,0,0,     0,0,0,4095,0);
        // commit 7, reset while pending, then zero entry
        add(1,7,1,0,0,0,     7,1,0,4095,0);
        add(1,7,0,0,0,0,     7,1,0,4095,0);
        add(1,0,0,1,0,0,     0,0,1,7,0);
        add(1,0,0,0,0,0,     0,0,1,7,0);
        add(0,0,0,0,0,0,     0,0,0,0,0);
        add(1,0,0,0,0,0,     0,0,0,0,0);
        add(1,0,1,0,0,0,     0,1,0,0,0);
        add(1,0,0,0,0,0,     0,1,0,0,0);
        add(1,0,0,1,0,0,     0,0,1,0,0);
        add(1,0,0,0,0,0,     0,0,1,0,0);
        // lido together with a tecla edge
        add(1,2,1,0,0,1,     0,0,0,0,1);
        add(1,2,0,0,0,0,     0,0,0,0,0);
        add(1,2,1,0,0,0,     2,1,0,0,0);
        add(1,2,0,0,0,0,     2,1,0,0,0);

        for (int i = 0; i < tab.size(); i++) begin
            cycle(tab[i].rst_n, tab[i].d, tab[i].t, tab[i].c,
                  tab[i].a, tab[i].l);
            check($sformatf("row%0d", i), tab[i].p, tab[i].n,
                  tab[i].v, tab[i].val, tab[i].e);
        end

        rt = 0;
        rc = 0;
        ra = 0;
        for (int k = 0; k < 4000; k++) begin
            bit r;
            int d;
            r = ($urandom_range(0, 199) != 0);
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
                                            : $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 0) rt = ~rt;
            if ($urandom_range(0, 9) == 0) rc = ~rc;
            if ($urandom_range(0, 29) == 0) ra = ~ra;
            cycle(r, d, rt, rc, ra, $urandom_range(0, 5) == 0);
            check($sformatf("rnd%0d", k), qval(), m_digs.size(),
                  m_pend, m_val, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
